// File: rtl/fma_sched_pkg.sv
// fma_sched_pkg: shared constants, phase/op enums and the operand triple type for fma_operand_sched
package fma_sched_pkg;
  localparam int SOF_BIT = 69;
  localparam int OP_HI = 68;
  localparam int OP_LO = 67;
  localparam int MANT_W = 64;
  localparam int TAG_W = 4;
  typedef enum logic [1:0] {OP_PADD, OP_PSUB, OP_NADD, OP_NSUB} op_e;
  typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_e;
  typedef struct packed {
    op_e op;
    logic [TAG_W-1:0] tag;
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic [MANT_W-1:0] c;
  } triple_t;
endpackage

// File: rtl/fma_sched_fifo.sv
// fma_sched_fifo: synchronous triple FIFO with a registered head and full/empty flags
module fma_sched_fifo
  import fma_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  triple_t din,
  output triple_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  triple_t mem_q [DEPTH];
  triple_t head_q, head_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic wr_en;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q - rd_q) == (AW+1)'(DEPTH);
    wr_en = push && (!full || pop);
    rd_d = rd_q + (AW+1)'(pop && !empty);
    wr_d = wr_q + (AW+1)'(wr_en);
    head_d = rd_d == wr_d ? head_q : rd_d == wr_q ? din : mem_q[rd_d[AW-1:0]];
    head = head_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      head_q <= head_d;
    end
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fma_operand_sched.sv
// fma_operand_sched: groups sipo words into FMA operand triples, queues and issues them with credit limiting (FMA_SCHED_STATS_EN adds counters)
module fma_operand_sched
  import fma_sched_pkg::*;
#(
  parameter int WORD_W = 70,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sipo_load,
  input  logic [WORD_W-1:0] sipo_dout,
  input  logic [TAG_W-1:0]  sipo_row,
  output logic              fma_valid,
  input  logic              fma_ready,
  output logic [1:0]        fma_op,
  output logic [MANT_W-1:0] fma_a,
  output logic [MANT_W-1:0] fma_b,
  output logic [MANT_W-1:0] fma_c,
  output logic [TAG_W-1:0]  fma_tag,
  input  logic              fma_res_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              ovf_err,
  output logic              unf_err
`ifdef FMA_SCHED_STATS_EN
  ,
  output logic [15:0]       issued_cnt,
  output logic [15:0]       dropped_cnt,
  output logic [15:0]       retired_cnt
`endif
);
  phase_e ph_q, ph_d;
  triple_t trip_q, trip_d, head;
  logic push_q, push_d, full, empty, acc, sof, issue, ret_ok, drop_w, drop_t;
  logic frame_q, frame_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [3:0] out_q, out_d;
  logic [MANT_W-1:0] word;
  fma_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push_q), .pop(issue), .din(trip_q),
    .head(head), .full(full), .empty(empty)
  );
  always_comb begin
    acc = en && sipo_load;
    sof = sipo_dout[SOF_BIT];
    word = sipo_dout[MANT_W-1:0];
    drop_w = acc && !sof && ph_q == PH_A;
    ph_d = !acc ? ph_q : sof ? PH_B : ph_q == PH_B ? PH_C : PH_A;
    trip_d = trip_q;
    if (acc && sof) begin
      trip_d.op = op_e'(sipo_dout[OP_HI:OP_LO]);
      trip_d.tag = sipo_row;
      trip_d.a = word;
    end
    if (acc && !sof && ph_q == PH_B) trip_d.b = word;
    if (acc && !sof && ph_q == PH_C) trip_d.c = word;
    push_d = acc && !sof && ph_q == PH_C;
    fma_valid = !empty && int'(out_q) < MAX_OUT;
    issue = fma_valid && fma_ready;
    drop_t = push_q && full && !issue;
    ret_ok = fma_res_valid && out_q != 4'd0;
    out_d = out_q + 4'(issue) - 4'(ret_ok);
    frame_d = frame_q || (acc && sof && ph_q != PH_A) || drop_w;
    ovf_d = ovf_q || drop_t;
    unf_d = unf_q || (fma_res_valid && out_q == 4'd0);
    {fma_op, fma_tag, fma_a, fma_b, fma_c} = head;
    busy = ph_q != PH_A || push_q || !empty || out_q != 4'd0;
    frame_err = frame_q;
    ovf_err = ovf_q;
    unf_err = unf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= PH_A;
      trip_q <= '0;
      push_q <= 1'b0;
      out_q <= '0;
      frame_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      trip_q <= trip_d;
      push_q <= push_d;
      out_q <= out_d;
      frame_q <= frame_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
`ifdef FMA_SCHED_STATS_EN
  logic [15:0] iss_q, iss_d, drp_q, drp_d, ret_q, ret_d;
  always_comb begin
    iss_d = iss_q + 16'(issue && iss_q != 16'hFFFF);
    drp_d = drp_q + 16'((drop_w || drop_t) && drp_q != 16'hFFFF);
    ret_d = ret_q + 16'(ret_ok && ret_q != 16'hFFFF);
    issued_cnt = iss_q;
    dropped_cnt = drp_q;
    retired_cnt = ret_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
      drp_q <= '0;
      ret_q <= '0;
    end else begin
      iss_q <= iss_d;
      drp_q <= drp_d;
      ret_q <= ret_d;
    end
  end
`endif
endmodule

// File: tb/tb_fma_operand_sched.sv
// tb_fma_operand_sched: directed self-checking bench for fma_operand_sched (DEPTH=4, MAX_OUT=2)
module tb_fma_operand_sched;
  logic clk, rst, en, sipo_load, fma_ready, fma_res_valid;
  logic [69:0] sipo_dout;
  logic [3:0] sipo_row, fma_tag;
  logic fma_valid, busy, frame_err, ovf_err, unf_err;
  logic [1:0] fma_op;
  logic [63:0] fma_a, fma_b, fma_c;
`ifdef FMA_SCHED_STATS_EN
  logic [15:0] issued_cnt, dropped_cnt, retired_cnt;
`endif
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [69:0] wa, wb, wc;
    logic [3:0] row;
    logic [1:0] eop;
    logic [3:0] etag;
    logic [63:0] ea, eb, ec;
  } vec_t;
  vec_t tv [4];
  fma_operand_sched #(.WORD_W(70), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sipo_load(sipo_load), .sipo_dout(sipo_dout),
    .sipo_row(sipo_row), .fma_valid(fma_valid), .fma_ready(fma_ready), .fma_op(fma_op),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_tag(fma_tag),
    .fma_res_valid(fma_res_valid), .busy(busy), .frame_err(frame_err),
    .ovf_err(ovf_err), .unf_err(unf_err)
`ifdef FMA_SCHED_STATS_EN
    , .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt), .retired_cnt(retired_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [69:0] w, input logic [3:0] r);
    sipo_load = 1'b1;
    sipo_dout = w;
    sipo_row = r;
    @(negedge clk);
    sipo_load = 1'b0;
  endtask
  function automatic logic [69:0] mk(input logic s, input logic [1:0] op, input logic [63:0] d);
    return {s, op, 3'b000, d};
  endfunction
  task automatic trip(input logic [1:0] op, input logic [3:0] tag, input logic [63:0] base);
    send(mk(1'b1, op, base), tag);
    send(mk(1'b0, 2'd0, base + 64'd1), 4'hE);
    send(mk(1'b0, 2'd0, base + 64'd2), 4'hD);
  endtask
  task automatic retire1;
    fma_res_valid = 1'b1;
    step(1);
    fma_res_valid = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask
  initial begin
    tv[0] = '{70'h20_4016000000000000, 70'h00_4023000000000000, 70'h00_40234CCCC0000000, 4'd3,
              2'd0, 4'd3, 64'h4016000000000000, 64'h4023000000000000, 64'h40234CCCC0000000};
    tv[1] = '{70'h28_3FF0000000000000, 70'h18_C000000000000000, 70'h07_0000000000000001, 4'd9,
              2'd1, 4'd9, 64'h3FF0000000000000, 64'hC000000000000000, 64'h0000000000000001};
    tv[2] = '{70'h30_FFFFFFFFFFFFFFFF, 70'h00_0000000000000000, 70'h00_7FF0000000000000, 4'd15,
              2'd2, 4'd15, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h7FF0000000000000};
    tv[3] = '{70'h3F_8000000000000000, 70'h00_0123456789ABCDEF, 70'h00_FEDCBA9876543210, 4'd0,
              2'd3, 4'd0, 64'h8000000000000000, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    rst = 1'b1; en = 1'b1; sipo_load = 1'b0; sipo_dout = '0; sipo_row = '0;
    fma_ready = 1'b0; fma_res_valid = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_valid", fma_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {frame_err, ovf_err, unf_err}, 0);
    chk("rst_head", {fma_op, fma_tag, fma_a}, 0);
`ifdef FMA_SCHED_STATS_EN
    chk("rst_stats", {issued_cnt, dropped_cnt, retired_cnt}, 0);
`endif
    fma_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(tv[i].wa, tv[i].row);
      send(tv[i].wb, 4'hE);
      send(tv[i].wc, 4'hD);
      chk("tbl_valid_early", fma_valid, 0);
      step(1);
      chk("tbl_valid", fma_valid, 1);
      chk("tbl_op", fma_op, tv[i].eop);
      chk("tbl_tag", fma_tag, tv[i].etag);
      chk("tbl_a", fma_a, tv[i].ea);
      chk("tbl_b", fma_b, tv[i].eb);
      chk("tbl_c", fma_c, tv[i].ec);
      step(1);
      chk("tbl_valid_once", fma_valid, 0);
      retire1;
      chk("tbl_idle", busy, 0);
    end
    chk("tbl_errs", {frame_err, ovf_err, unf_err}, 0);
    do_reset;
    fma_ready = 1'b0;
    for (int k = 0; k < 4; k++) trip(2'd0, 4'(k), 64'h1000 + 64'(k * 16));
    step(1);
    chk("bp_full_no_ovf", ovf_err, 0);
    chk("bp_head0", fma_a, 64'h1000);
    for (int k = 4; k < 6; k++) trip(2'd0, 4'(k), 64'h1000 + 64'(k * 16));
    step(1);
    chk("bp_ovf", ovf_err, 1);
    chk("bp_head_stable", fma_a, 64'h1000);
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", fma_valid, 1);
      chk("bp_order_a", fma_a, 64'h1000 + 64'(k * 16));
      chk("bp_order_tag", fma_tag, 4'(k));
      fma_ready = 1'b1;
      step(1);
      fma_ready = 1'b0;
      retire1;
    end
    chk("bp_drained", fma_valid, 0);
    chk("bp_idle", busy, 0);
`ifdef FMA_SCHED_STATS_EN
    chk("st_issued", issued_cnt, 4);
    chk("st_dropped", dropped_cnt, 2);
    chk("st_retired", retired_cnt, 4);
`endif
    do_reset;
    for (int k = 0; k < 3; k++) trip(2'd1, 4'(k), 64'h2000 + 64'(k * 16));
    step(1);
    chk("cr_valid0", fma_valid, 1);
    chk("cr_a0", fma_a, 64'h2000);
    fma_ready = 1'b1;
    step(1);
    chk("cr_valid1", fma_valid, 1);
    chk("cr_a1", fma_a, 64'h2010);
    step(1);
    chk("cr_blocked", fma_valid, 0);
    chk("cr_head2", fma_a, 64'h2020);
    step(2);
    chk("cr_still_blocked", fma_valid, 0);
    fma_res_valid = 1'b1;
    step(1);
    chk("cr_released", fma_valid, 1);
    chk("cr_a2", fma_a, 64'h2020);
    step(1);
    fma_res_valid = 1'b0;
    chk("cr_empty", fma_valid, 0);
    chk("cr_busy_out1", busy, 1);
    retire1;
    chk("cr_idle", busy, 0);
    chk("cr_no_unf", unf_err, 0);
    retire1;
    chk("cr_unf", unf_err, 1);
    fma_ready = 1'b0;
    do_reset;
    fma_ready = 1'b1;
    en = 1'b0;
    send(mk(1'b0, 2'd0, 64'h1), 4'd1);
    chk("en_low_ignored", frame_err, 0);
    en = 1'b1;
    send(mk(1'b1, 2'd0, 64'h3FFF), 4'd5);
    send(mk(1'b1, 2'd1, 64'h3000), 4'd6);
    chk("fr_sof_sof", frame_err, 1);
    send(mk(1'b0, 2'd0, 64'h3001), 4'd7);
    send(mk(1'b0, 2'd0, 64'h3002), 4'd8);
    step(1);
    chk("fr_valid", fma_valid, 1);
    chk("fr_op", fma_op, 2'd1);
    chk("fr_tag", fma_tag, 4'd6);
    chk("fr_abc", {fma_a[15:0], fma_b[15:0], fma_c[15:0]}, 48'h3000_3001_3002);
    step(1);
    retire1;
    do_reset;
    send(mk(1'b0, 2'd0, 64'h5000), 4'd1);
    chk("fr_nosof", frame_err, 1);
    send(mk(1'b0, 2'd0, 64'h5001), 4'd1);
    send(mk(1'b0, 2'd0, 64'h5002), 4'd1);
    step(3);
    chk("fr_dropped", {fma_valid, busy}, 0);
    trip(2'd2, 4'd4, 64'h6000);
    step(1);
    chk("fr_recover", fma_a, 64'h6000);
    chk("fr_recover_v", fma_valid, 1);
    step(1);
    retire1;
    do_reset;
    send(mk(1'b0, 2'd0, 64'h1), 4'd1);
    trip(2'd0, 4'd1, 64'h4000);
    step(2);
    fma_ready = 1'b0;
    trip(2'd0, 4'd2, 64'h4100);
    trip(2'd0, 4'd3, 64'h4200);
    send(mk(1'b1, 2'd0, 64'h4300), 4'd4);
    send(mk(1'b0, 2'd0, 64'h4301), 4'd4);
    step(1);
    chk("rm_busy", busy, 1);
    chk("rm_frame", frame_err, 1);
    do_reset;
    chk("rm_cleared", {busy, fma_valid}, 0);
    chk("rm_errs", {frame_err, ovf_err, unf_err}, 0);
    chk("rm_head", fma_a, 0);
    retire1;
    chk("rm_stray_unf", unf_err, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
